// File: rtl/fb_pkg.sv
// Shared frame-buffer geometry, FSM encoding and word-address helper.
package fb_pkg;

   localparam int BLK_WIDTH = 8;
   localparam int MEM_WIDTH = BLK_WIDTH * 8;
   localparam int ADDR_W    = 21;
   localparam int GEOM_W    = 12;
   localparam int POS_W     = 11;
   localparam int OFF_W     = 2 * GEOM_W;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   // Pixel offset to memory word address; bits beyond ADDR_W are dropped.
   function automatic logic [ADDR_W-1:0] word_addr(input logic [OFF_W-1:0] pix_off);
      return ADDR_W'(pix_off >> $clog2(MEM_WIDTH / 8));
   endfunction

endpackage

// File: rtl/rd_lat_pipe.sv
// Valid/tag shift register that follows each memory strobe through the read latency.
// Latency DEPTH cycles from in_vld to out_vld; no backpressure, clr flushes every stage.
module rd_lat_pipe #(
   parameter int DEPTH = 2,
   parameter int TAG_W = 3
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             in_vld,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_vld,
   output logic [TAG_W-1:0] out_tag,
   output logic             any_vld
);

   logic [DEPTH-1:0] vld;
   logic [TAG_W-1:0] tag [DEPTH];

   always_ff @(posedge clk) begin
      if (clr) begin
         vld <= '0;
      end else begin
         vld[0] <= in_vld;
         for (int i = 1; i < DEPTH; i++) vld[i] <= vld[i-1];
      end
   end

   // Tags are only meaningful alongside a set valid bit, so they need no clear.
   always_ff @(posedge clk) begin
      tag[0] <= in_tag;
      for (int i = 1; i < DEPTH; i++) tag[i] <= tag[i-1];
   end

   assign out_vld = vld[DEPTH-1];
   assign out_tag = tag[DEPTH-1];
   assign any_vld = |vld;

endmodule

// File: rtl/block_loader.sv
// Fetches a BLK_WIDTH x BLK_WIDTH pixel block line by line, clamping rows below the frame.
// First line MEM_LAT+1 cycles after the first mem_read; no backpressure, consumer takes every line.
module block_loader
   import fb_pkg::*;
#(
   parameter int MEM_WIDTH = fb_pkg::MEM_WIDTH,
   parameter int BLK_WIDTH = fb_pkg::BLK_WIDTH,
   parameter int MEM_LAT   = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [11:0]                  stride_in,
   input  logic [11:0]                  height_in,
   input  logic                         setup_frame,
   input  logic [10:0]                  x,
   input  logic [10:0]                  y,
   input  logic                         read_block,
   output logic                         busy,
   output logic [20:0]                  mem_addr,
   output logic                         mem_read,
   input  logic [MEM_WIDTH-1:0]         mem_data,
   output logic [BLK_WIDTH*8-1:0]       blk_line,
   output logic                         blk_line_rdy,
   output logic [$clog2(BLK_WIDTH)-1:0] blk_row,
   output logic                         blk_done
);

   localparam int ROW_W = $clog2(BLK_WIDTH);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(BLK_WIDTH - 1);

   state_t            state;
   logic [GEOM_W-1:0] stride;
   logic [GEOM_W-1:0] height;
   logic [POS_W-1:0]  x_q;
   logic [POS_W-1:0]  y_q;
   logic [ROW_W-1:0]  r;
   logic [ROW_W-1:0]  mem_row;

   logic [GEOM_W-1:0] y_r;
   logic [GEOM_W-1:0] ry;
   logic [OFF_W-1:0]  pix_off;
   logic              pipe_vld;
   logic              pipe_any;
   logic [ROW_W-1:0]  pipe_row;

   // Rows past the frame bottom re-read the last valid row.
   always_comb begin
      y_r     = GEOM_W'(y_q) + GEOM_W'(r);
      ry      = (y_r < height) ? y_r : height - GEOM_W'(1);
      pix_off = OFF_W'(ry) * OFF_W'(stride) + OFF_W'(x_q);
   end

   rd_lat_pipe #(
      .DEPTH (MEM_LAT),
      .TAG_W (ROW_W)
   ) u_rd_lat_pipe (
      .clk     (clk),
      .clr     (reset),
      .in_vld  (mem_read),
      .in_tag  (mem_row),
      .out_vld (pipe_vld),
      .out_tag (pipe_row),
      .any_vld (pipe_any)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         stride       <= '0;
         height       <= '0;
         x_q          <= '0;
         y_q          <= '0;
         r            <= '0;
         mem_row      <= '0;
         busy         <= 1'b0;
         mem_read     <= 1'b0;
         mem_addr     <= '0;
         blk_line     <= '0;
         blk_line_rdy <= 1'b0;
         blk_row      <= '0;
         blk_done     <= 1'b0;
      end else begin
         mem_read     <= 1'b0;
         blk_line_rdy <= pipe_vld;
         blk_done     <= pipe_vld && (pipe_row == LAST_ROW);
         if (pipe_vld) begin
            blk_line <= mem_data;
            blk_row  <= pipe_row;
         end

         case (state)
            IDLE: begin
               if (setup_frame) begin
                  stride <= stride_in;
                  height <= height_in;
               end else if (read_block) begin
                  x_q   <= x;
                  y_q   <= y;
                  r     <= '0;
                  busy  <= 1'b1;
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               mem_read <= 1'b1;
               mem_addr <= word_addr(pix_off);
               mem_row  <= r;
               r        <= r + ROW_W'(1);
               if (r == LAST_ROW) state <= DRAIN;
            end
            DRAIN: begin
               // The last strobe is still in mem_read on the first DRAIN cycle.
               if (!mem_read && !pipe_any) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_block_loader.sv
// Bench for block_loader: table of block reads plus hand sequences, checked against a scoreboard.
module tb_block_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] stride_in;
   logic [11:0] height_in;
   logic        setup_frame;
   logic        read_block;
   logic [10:0] x;
   logic [10:0] y;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;
   int sel   = 0;
   int first_rd, first_rdy, last_rdy, rd_cnt, done_cnt, rb_cyc;
   logic [2:0] busy_v;

   logic [20:0] addr_q[$];
   logic [23:0] line_q[$];

   typedef struct packed {
      logic [11:0]      stride;
      logic [11:0]      height;
      logic [10:0]      bx;
      logic [10:0]      by;
      logic [7:0][20:0] a;
   } vec_t;

   vec_t tbl[6];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic int lat_of(input int g);
      return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
   endfunction

   function automatic vec_t mk(input int s, input int h, input int bx, input int by,
                               input int a0, input int a1, input int a2, input int a3,
                               input int a4, input int a5, input int a6, input int a7);
      vec_t v;
      v.stride = 12'(s);
      v.height = 12'(h);
      v.bx     = 11'(bx);
      v.by     = 11'(by);
      v.a[0] = 21'(a0); v.a[1] = 21'(a1); v.a[2] = 21'(a2); v.a[3] = 21'(a3);
      v.a[4] = 21'(a4); v.a[5] = 21'(a5); v.a[6] = 21'(a6); v.a[7] = 21'(a7);
      return v;
   endfunction

   // Three loaders differing only in memory latency; only the one selected by sel gets read_block.
   for (genvar g = 0; g < 3; g++) begin : inst
      localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
      logic        busy, mem_read, blk_line_rdy, blk_done;
      logic [20:0] mem_addr;
      logic [63:0] mem_data, blk_line;
      logic [2:0]  blk_row;
      logic [63:0] pd [LAT];
      logic [23:0] e;

      block_loader #(.MEM_WIDTH(64), .BLK_WIDTH(8), .MEM_LAT(LAT)) dut (
         .clk          (clk),
         .reset        (reset),
         .stride_in    (stride_in),
         .height_in    (height_in),
         .setup_frame  (setup_frame),
         .x            (x),
         .y            (y),
         .read_block   (read_block && (sel == g)),
         .busy         (busy),
         .mem_addr     (mem_addr),
         .mem_read     (mem_read),
         .mem_data     (mem_data),
         .blk_line     (blk_line),
         .blk_line_rdy (blk_line_rdy),
         .blk_row      (blk_row),
         .blk_done     (blk_done)
      );

      assign busy_v[g] = busy;

      // Memory returns its own word address, LAT cycles after the strobe.
      always @(posedge clk) begin
         pd[0] <= mem_read ? {43'b0, mem_addr} : 64'hBAD0_BAD0_BAD0_BAD0;
         for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
      end
      assign mem_data = pd[LAT-1];

      always @(negedge clk) begin
         if (sel == g) begin
            if (mem_read) begin
               rd_cnt++;
               if (first_rd < 0) first_rd = cyc;
               if (addr_q.size() == 0) check("unexpected_read", 64'(mem_read), 64'd0);
               else check("mem_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
            end
            if (blk_line_rdy) begin
               if (first_rdy < 0) first_rdy = cyc;
               else check("line_gap", 64'(cyc - last_rdy), 64'd1);
               last_rdy = cyc;
               if (blk_done) done_cnt++;
               if (line_q.size() == 0) begin
                  check("unexpected_rdy", 64'(blk_line_rdy), 64'd0);
               end else begin
                  e = line_q.pop_front();
                  check("blk_line", blk_line, {43'b0, e[20:0]});
                  check("blk_row", 64'(blk_row), 64'(e[23:21]));
                  check("blk_done", 64'(blk_done), 64'(e[23:21] == 3'd7));
               end
            end
         end else begin
            check("idle_inst", 64'({busy, mem_read, blk_line_rdy}), 64'd0);
         end
      end
   end

   task automatic setup(input int s, input int h);
      stride_in   = 12'(s);
      height_in   = 12'(h);
      setup_frame = 1'b1;
      @(posedge clk); #1;
      setup_frame = 1'b0;
   endtask

   task automatic push_model(input int s, input int h, input int bx, input int by);
      for (int r = 0; r < 8; r++) begin
         int ry, a;
         ry = (by + r < h) ? by + r : h - 1;
         a  = (ry * s + bx) >> 3;
         addr_q.push_back(a[20:0]);
         line_q.push_back({3'(r), a[20:0]});
      end
   endtask

   task automatic push_tbl(input int i);
      for (int r = 0; r < 8; r++) begin
         addr_q.push_back(tbl[i].a[r]);
         line_q.push_back({3'(r), tbl[i].a[r]});
      end
   endtask

   task automatic start_block(input logic [10:0] bx, input logic [10:0] by);
      x          = bx;
      y          = by;
      first_rd   = -1;
      first_rdy  = -1;
      rd_cnt     = 0;
      done_cnt   = 0;
      rb_cyc     = cyc;
      read_block = 1'b1;
      @(posedge clk); #1;
      read_block = 1'b0;
      check("busy_rise", 64'(busy_v[sel]), 64'd1);
   endtask

   // Returns in the first cycle with busy low, so a new read can be issued right away.
   task automatic finish_block();
      int n = 0;
      while (busy_v[sel] && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("busy_timeout", 64'(busy_v[sel]), 64'd0);
      check("rd_count", 64'(rd_cnt), 64'd8);
      check("done_count", 64'(done_cnt), 64'd1);
      check("rd_start", 64'(first_rd - rb_cyc), 64'd2);
      check("rdy_latency", 64'(first_rdy - first_rd), 64'(lat_of(sel) + 1));
      check("busy_fall", 64'(cyc - last_rdy), 64'd1);
      check("addr_left", 64'(addr_q.size()), 64'd0);
      check("line_left", 64'(line_q.size()), 64'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running, expected $finish long before");
      $fatal(1);
   end

   initial begin
      int rc;
      tbl[0] = mk(64,   32,   8,    0,    1, 9, 17, 25, 33, 41, 49, 57);
      tbl[1] = mk(64,   20,   0,    16,   128, 136, 144, 152, 152, 152, 152, 152);
      tbl[2] = mk(128,  100,  16,   3,    50, 66, 82, 98, 114, 130, 146, 162);
      tbl[3] = mk(64,   1,    56,   5,    7, 7, 7, 7, 7, 7, 7, 7);
      tbl[4] = mk(4088, 4095, 2040, 2047, 1046272, 1046783, 1047294, 1047805,
                  1048316, 1048827, 1049338, 1049849);
      tbl[5] = mk(64,   10,   0,    12,   72, 72, 72, 72, 72, 72, 72, 72);

      reset       = 1'b1;
      setup_frame = 1'b0;
      read_block  = 1'b0;
      stride_in   = '0;
      height_in   = '0;
      x           = '0;
      y           = '0;
      sel         = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 64'(inst[0].busy), 64'd0);
      check("rst_mem_read", 64'(inst[0].mem_read), 64'd0);
      check("rst_mem_addr", 64'(inst[0].mem_addr), 64'd0);
      check("rst_blk_line", inst[0].blk_line, 64'd0);
      check("rst_rdy", 64'(inst[0].blk_line_rdy), 64'd0);
      check("rst_row", 64'(inst[0].blk_row), 64'd0);
      check("rst_done", 64'(inst[0].blk_done), 64'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) begin
         setup(int'(tbl[i].stride), int'(tbl[i].height));
         push_tbl(i);
         start_block(tbl[i].bx, tbl[i].by);
         finish_block();
      end

      // Second read_block and a setup_frame during the block are both ignored.
      setup(64, 32);
      push_model(64, 32, 16, 0);
      start_block(11'd16, 11'd0);
      repeat (2) begin @(posedge clk); #1; end
      x           = 11'd0;
      stride_in   = 12'd128;
      read_block  = 1'b1;
      setup_frame = 1'b1;
      @(posedge clk); #1;
      read_block  = 1'b0;
      setup_frame = 1'b0;
      finish_block();
      push_model(64, 32, 0, 0);
      start_block(11'd0, 11'd0);
      finish_block();

      // Setup and read in the same IDLE cycle: setup is taken, the read is dropped.
      stride_in   = 12'd128;
      height_in   = 12'd50;
      setup_frame = 1'b1;
      read_block  = 1'b1;
      @(posedge clk); #1;
      setup_frame = 1'b0;
      read_block  = 1'b0;
      repeat (4) begin
         check("same_busy", 64'(inst[0].busy), 64'd0);
         check("same_read", 64'(inst[0].mem_read), 64'd0);
         @(posedge clk); #1;
      end
      push_model(128, 50, 0, 45);
      start_block(11'd0, 11'd45);
      finish_block();

      // Reset sampled at the end of the 4th ISSUE cycle aborts the block.
      setup(64, 32);
      push_model(64, 32, 0, 0);
      start_block(11'd0, 11'd0);
      repeat (3) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort_mem_read", 64'(inst[0].mem_read), 64'd0);
      check("abort_busy", 64'(inst[0].busy), 64'd0);
      addr_q.delete();
      line_q.delete();
      rc = 0;
      repeat (12) begin
         @(negedge clk);
         rc += int'(inst[0].blk_line_rdy);
      end
      check("abort_no_rdy", 64'(rc), 64'd0);
      @(posedge clk); #1;
      setup(64, 32);
      push_model(64, 32, 24, 3);
      start_block(11'd24, 11'd3);
      finish_block();

      // Back-to-back blocks at each memory latency.
      for (int g = 0; g < 3; g++) begin
         sel = g;
         setup(64, 32);
         push_model(64, 32, 0, 0);
         start_block(11'd0, 11'd0);
         finish_block();
         push_model(64, 32, 8, 8);
         start_block(11'd8, 11'd8);
         finish_block();
      end

      repeat (4) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/block_loader.md
Name: block_loader

Overview:
- Pixel-loader stage between the shared frame memory and the block-processing datapath.
- On a read_block pulse it fetches one BLK_WIDTH x BLK_WIDTH block of 8-bit pixels, one BLK_WIDTH-pixel line per memory word, and streams the lines out in row order.
- It pipelines reads against a fixed-latency memory port.
- It clamps rows below the frame bottom by replicating the last valid row.

Parameters:
- MEM_WIDTH, 64, memory word width in bits; must equal BLK_WIDTH*8.
- BLK_WIDTH, 8, block edge in pixels; also the number of lines per block.
- MEM_LAT, 2, cycles from mem_read asserted to mem_data valid; range 1..4.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- stride_in  input  12  line pitch in pixels; multiple of BLK_WIDTH.
- height_in  input  12  frame height in lines; must be >= 1.
- setup_frame  input  1  load stride/height; honoured only in IDLE.
- x  input  11  block left pixel column; multiple of BLK_WIDTH.
- y  input  11  block top line.
- read_block  input  1  start pulse; honoured only in IDLE.
- busy  output  1  high from the accepted start through the last line out.
- mem_addr  output  21  word address of the line being read.
- mem_read  output  1  read strobe, one word per cycle.
- mem_data  input  MEM_WIDTH  read data, valid MEM_LAT cycles after the strobe.
- blk_line  output  BLK_WIDTH*8  pixel line; pixel 0 in bits [7:0].
- blk_line_rdy  output  1  one-cycle qualifier for blk_line.
- blk_row  output  3  row index of blk_line (log2 BLK_WIDTH bits).
- blk_done  output  1  pulse coincident with the last blk_line_rdy.

Behaviour:
- Reset values: busy=0, mem_read=0, mem_addr=0, blk_line=0, blk_line_rdy=0, blk_row=0, blk_done=0. stride and height registers reset to 0. Latency pipe cleared. FSM goes to IDLE.
- Reset asserted mid-block aborts the block. No rdy is produced after the reset cycle, and data still in flight from memory is discarded.
- States:
  - IDLE: setup_frame=1 latches stride_in and height_in. Otherwise read_block=1 latches x and y, clears the row counter r, and moves to ISSUE; busy rises the next cycle. If setup_frame and read_block are both high, setup wins and read_block is dropped.
  - ISSUE: mem_read=1 for exactly BLK_WIDTH consecutive cycles, r = 0..BLK_WIDTH-1.
    - Row address: ry = y+r if y+r < height, else height-1 (clamp).
    - mem_addr = (ry*stride + x) >> 3, computed 24 bits wide and truncated to 21.
    - After r=BLK_WIDTH-1, go to DRAIN.
  - DRAIN: wait until the latency pipe is empty, then go to IDLE with busy=0. busy falls the cycle after the last blk_line_rdy.
- Latency pipe: a MEM_LAT-deep shift register of {valid, row} tracks each strobe.
  - When the pipe output is valid: blk_line is registered from mem_data, blk_line_rdy=1, and blk_row=row.
  - blk_done=1 together with rdy when row=BLK_WIDTH-1.
  - Total latency: first blk_line_rdy comes MEM_LAT+1 cycles after the first mem_read. Lines then arrive on consecutive cycles.
- No backpressure: the consumer must accept every rdy cycle.
- blk_line holds its value between rdy pulses.
- read_block or setup_frame while busy is ignored; inputs are not queued.
- x and stride alignment are the caller's responsibility. Low bits of x are truncated by the >>3.

Decomposition:
- Shared package fb_pkg:
  - BLK_WIDTH and MEM_WIDTH defaults.
  - Address and geometry widths (ADDR_W=21, GEOM_W=12, POS_W=11).
  - FSM state encoding {IDLE, ISSUE, DRAIN}.
  - Word-address function: pixel offset >> log2(MEM_WIDTH/8).
- One natural sub-module, rd_lat_pipe: a parameterised MEM_LAT-deep valid/tag shift register with a synchronous clear. block_loader keeps the FSM, address generation and output registers.

Test Plan:
- Setup stride=64, height=32. Pulse read_block at x=8, y=0, MEM_LAT=2, with the memory model returning data=address.
  - mem_addr must read 1, 9, 17, …, 57 on 8 consecutive cycles.
  - blk_line_rdy must follow starting 3 cycles after the first mem_read, with blk_row 0..7.
  - blk_done must pulse on row 7.
- Bottom clamp: height=20, read at x=0, y=16 → rows 16..19 give addresses 128, 136, 144, 152; rows 4..7 all give 152.
- Ignore while busy: pulse read_block with x=16, and a second read_block 3 cycles later → exactly 8 mem_read cycles and one blk_done. setup_frame with stride=128 during the block must leave the addresses unchanged.
- Reset mid-operation: assert reset on the 4th ISSUE cycle → the next cycle mem_read=0 and busy=0, and no blk_line_rdy ever appears. A fresh read_block afterwards completes normally.
- Same-cycle setup_frame and read_block in IDLE → stride and height are updated, no read starts, and busy stays 0.
- Back-to-back blocks: issue read_block the cycle after busy falls → the second block's addresses start on the following cycle. Sweep MEM_LAT=1 and MEM_LAT=4 and check the line order and count stay correct.
